// File: rtl/sample_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mp3_pkg
// Shared types and constants for the SDRAM sample fetch path of mp3player_soc.
//   fs_state_t   : bridge sequencing states of sample_fetch_ctrl
//   SAMPLE_W     : audio sample / SDRAM word width
//   BYTE_EN_FULL : both byte lanes enabled
//   sat_inc8     : 8-bit increment that sticks at 8'hFF
// ---------------------------------------------------------------------------
package mp3_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [1:0] BYTE_EN_FULL = 2'b11;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_WRITE = 2'd1,
        FS_READ  = 2'd2,
        FS_GAP   = 2'd3
    } fs_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sample_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// sample_fetch_ctrl_if
// Avalon bridge port used by sample_fetch_ctrl to reach SDRAM.
//   bridge_addr     : word address            (master -> slave)
//   bridge_byte_en  : byte lane enables       (master -> slave)
//   bridge_read     : read strobe             (master -> slave)
//   bridge_write    : write strobe            (master -> slave)
//   bridge_wr_data  : write data              (master -> slave)
//   bridge_ack      : transaction acknowledge (slave -> master)
//   bridge_rd_data  : read data, valid with bridge_ack (slave -> master)
// ---------------------------------------------------------------------------
interface sample_fetch_ctrl_if
    import mp3_pkg::*;
#(
    parameter int ADDR_W = 26
);

    logic [ADDR_W-1:0]   bridge_addr;
    logic [1:0]          bridge_byte_en;
    logic                bridge_read;
    logic                bridge_write;
    logic [SAMPLE_W-1:0] bridge_wr_data;
    logic                bridge_ack;
    logic [SAMPLE_W-1:0] bridge_rd_data;

    modport master (
        output bridge_addr,
        output bridge_byte_en,
        output bridge_read,
        output bridge_write,
        output bridge_wr_data,
        input  bridge_ack,
        input  bridge_rd_data
    );

    modport slave (
        input  bridge_addr,
        input  bridge_byte_en,
        input  bridge_read,
        input  bridge_write,
        input  bridge_wr_data,
        output bridge_ack,
        output bridge_rd_data
    );

endinterface

// File: rtl/sample_fetch_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Small synchronous FIFO holding audio samples between the SDRAM reader and
// the I2S serializer. DEPTH must be a power of two and at least 2 so the
// read/write pointers wrap naturally.
//   clk, reset : clock and synchronous active-high reset
//   push       : write push_data (ignored when full)
//   push_data  : sample to store
//   pop        : discard the head entry (ignored when empty)
//   head       : oldest stored sample
//   count      : number of stored samples, 0..DEPTH
//   full/empty : count == DEPTH / count == 0
// ---------------------------------------------------------------------------
module sample_fifo
    import mp3_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [SAMPLE_W-1:0]       push_data,
    input  logic                      pop,
    output logic [SAMPLE_W-1:0]       head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic [SAMPLE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                do_push;
    logic                do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage itself is not cleared; the pointers make stale entries invisible.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sample_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// sample_fetch_ctrl
// Sequencer and arbiter for the SDRAM Avalon bridge port. While the SD-card
// loader is running, its word writes own the bridge. Once loading is done and
// play is enabled, 16-bit samples are streamed from a circular SDRAM region
// [BASE_ADDR, BASE_ADDR+LEN-1] into a small FIFO. Each sample_req from the
// I2S serializer is answered one cycle later with the FIFO head, or with
// silence and an underrun count when the FIFO is empty.
//   Clk, Reset     : clock and synchronous active-high reset
//   load_we        : loader word pending (held until load_ack)
//   load_addr/data : loader word address / data
//   load_done      : loader finished (level)
//   load_ack       : one-cycle pulse, loader word committed
//   play           : 1 = stream samples, 0 = pause
//   bridge         : Avalon bridge master port
//   sample_req     : one-cycle request from the serializer
//   sample_out     : sample handed to the serializer
//   sample_valid   : one-cycle pulse, sample_out valid
//   underrun_cnt   : saturating count of requests that found the FIFO empty
// ---------------------------------------------------------------------------
module sample_fetch_ctrl
    import mp3_pkg::*;
#(
    parameter int                ADDR_W     = 26,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(26'h0000000),
    parameter logic [ADDR_W-1:0] LEN        = ADDR_W'(26'h0100000)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  load_we,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [SAMPLE_W-1:0]   load_data,
    input  logic                  load_done,
    output logic                  load_ack,
    input  logic                  play,
    sample_fetch_ctrl_if.master   bridge,
    input  logic                  sample_req,
    output logic [SAMPLE_W-1:0]   sample_out,
    output logic                  sample_valid,
    output logic [7:0]            underrun_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    // Last word of the sample loop; wraps modulo 2**ADDR_W like the pointer.
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + LEN - ADDR_W'(1);

    fs_state_t           state_q, state_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          byte_en_q, byte_en_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
    logic                load_ack_q, load_ack_d;
    logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
    logic                sample_valid_q, sample_valid_d;
    logic [7:0]          underrun_q, underrun_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic [SAMPLE_W-1:0] fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_has_room;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .reset     (Reset),
        .push      (fifo_push),
        .push_data (bridge.bridge_rd_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Reads are only launched with a free slot, and only one transaction is
    // ever outstanding, so the pushed word always fits.
    assign fifo_has_room = (fifo_count < DEPTH_CNT);

    // Bridge sequencing. Every bridge output is computed one cycle ahead so it
    // comes straight from a flop: strobes rise the cycle after the FS_IDLE
    // decision and drop on the edge that samples bridge_ack. FS_GAP gives the
    // loader a cycle to present its next word after load_ack.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        addr_d     = addr_q;
        byte_en_d  = byte_en_q;
        read_d     = read_q;
        write_d    = write_q;
        wr_data_d  = wr_data_q;
        load_ack_d = 1'b0;
        fifo_push  = 1'b0;

        case (state_q)
            FS_IDLE: begin
                if (load_we && !load_done) begin
                    state_d   = FS_WRITE;
                    write_d   = 1'b1;
                    addr_d    = load_addr;
                    wr_data_d = load_data;
                    byte_en_d = BYTE_EN_FULL;
                end else if (load_done && play && fifo_has_room) begin
                    state_d   = FS_READ;
                    read_d    = 1'b1;
                    addr_d    = rd_ptr_q;
                    byte_en_d = BYTE_EN_FULL;
                end
            end
            FS_WRITE: begin
                if (bridge.bridge_ack) begin
                    state_d    = FS_GAP;
                    write_d    = 1'b0;
                    addr_d     = '0;
                    wr_data_d  = '0;
                    byte_en_d  = '0;
                    load_ack_d = 1'b1;
                end
            end
            FS_READ: begin
                // A read already on the bus finishes even if play drops.
                if (bridge.bridge_ack) begin
                    state_d   = FS_GAP;
                    read_d    = 1'b0;
                    addr_d    = '0;
                    byte_en_d = '0;
                    fifo_push = !fifo_full;
                    rd_ptr_d  = (rd_ptr_q == LAST_ADDR) ? BASE_ADDR
                                                        : rd_ptr_q + ADDR_W'(1);
                end
            end
            FS_GAP: begin
                state_d = FS_IDLE;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    // Serializer side runs independently of play. An empty FIFO answers with
    // silence; a pop and a same-cycle read push both land on the next edge.
    always_comb begin
        sample_valid_d = sample_req;
        sample_out_d   = sample_out_q;
        underrun_d     = underrun_q;
        fifo_pop       = sample_req && !fifo_empty;
        if (sample_req) begin
            if (fifo_empty) begin
                sample_out_d = '0;
                underrun_d   = sat_inc8(underrun_q);
            end else begin
                sample_out_d = fifo_head;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= FS_IDLE;
            rd_ptr_q       <= BASE_ADDR;
            addr_q         <= '0;
            byte_en_q      <= '0;
            read_q         <= 1'b0;
            write_q        <= 1'b0;
            wr_data_q      <= '0;
            load_ack_q     <= 1'b0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
            underrun_q     <= '0;
        end else begin
            state_q        <= state_d;
            rd_ptr_q       <= rd_ptr_d;
            addr_q         <= addr_d;
            byte_en_q      <= byte_en_d;
            read_q         <= read_d;
            write_q        <= write_d;
            wr_data_q      <= wr_data_d;
            load_ack_q     <= load_ack_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            underrun_q     <= underrun_d;
        end
    end

    assign bridge.bridge_addr    = addr_q;
    assign bridge.bridge_byte_en = byte_en_q;
    assign bridge.bridge_read    = read_q;
    assign bridge.bridge_write   = write_q;
    assign bridge.bridge_wr_data = wr_data_q;

    assign load_ack     = load_ack_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_sample_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sample_fetch_ctrl
// Drives sample_fetch_ctrl as loader, SDRAM bridge slave and I2S serializer.
// A queue-based model of the sample stream predicts every sample, the
// circular read address sequence, load_ack pulses and the underrun counter.
// A short loop (LEN=6) is used so wrap-around happens often.
// ---------------------------------------------------------------------------
module tb_sample_fetch_ctrl;
    import mp3_pkg::*;

    localparam int                ADDR_W = 26;
    localparam int                DEPTH  = 4;
    localparam logic [ADDR_W-1:0] BASE   = 26'h0;
    localparam int                LEN    = 6;

    logic                clk = 1'b0;
    logic                reset;
    logic                load_we;
    logic [ADDR_W-1:0]   load_addr;
    logic [SAMPLE_W-1:0] load_data;
    logic                load_done;
    logic                load_ack;
    logic                play;
    logic                sample_req;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic [7:0]          underrun_cnt;

    sample_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    sample_fetch_ctrl #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE),
        .LEN        (26'd6)
    ) dut (
        .Clk          (clk),
        .Reset        (reset),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_done    (load_done),
        .load_ack     (load_ack),
        .play         (play),
        .bridge       (bus.master),
        .sample_req   (sample_req),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state
    logic [SAMPLE_W-1:0] model_q[$];
    int                  rd_idx         = 0;
    int                  underrun_model = 0;
    bit                  exp_valid      = 1'b0;
    logic [SAMPLE_W-1:0] exp_out        = '0;
    bit                  exp_load_ack   = 1'b0;
    int                  edges_since_ack = 0;
    bit                  any_ack        = 1'b0;
    bit                  prev_strobe    = 1'b0;

    // Loader words still to be committed
    logic [ADDR_W-1:0]   ld_addr_q[$];
    logic [SAMPLE_W-1:0] ld_data_q[$];

    // Bridge responder / stimulus knobs
    int ack_lat    = 0;
    int wait_cnt   = 0;
    bit junk_we    = 1'b0;
    bit req_on_ack = 1'b0;

    int read_count     = 0;
    int write_count    = 0;
    int load_ack_count = 0;
    int valid_count    = 0;
    int cnt_before     = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp_v);
        n_compared++;
        if (got !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp_v);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, let the rising edge
    // happen, advance the model with what the DUT saw, then check outputs.
    task automatic applyStimulus(input bit rst_i, input bit req_i);
        bit                  ev_rst, ev_req, ev_rd_ack, ev_wr_ack;
        logic [SAMPLE_W-1:0] ev_data;

        @(negedge clk);
        reset = rst_i;
        if (ld_addr_q.size() > 0) begin
            load_we   = 1'b1;
            load_addr = ld_addr_q[0];
            load_data = ld_data_q[0];
        end else begin
            load_we   = junk_we;
            load_addr = ADDR_W'($urandom);
            load_data = SAMPLE_W'($urandom);
        end
        if ((bus.bridge_read || bus.bridge_write) && !rst_i) begin
            bus.bridge_ack = (wait_cnt >= ack_lat);
            wait_cnt++;
        end else begin
            bus.bridge_ack = 1'b0;
            wait_cnt = 0;
        end
        if (bus.bridge_read && bus.bridge_ack)
            bus.bridge_rd_data = 16'h1000 + bus.bridge_addr[15:0];
        else
            bus.bridge_rd_data = SAMPLE_W'($urandom);
        sample_req = req_i || (req_on_ack && bus.bridge_read && bus.bridge_ack);

        ev_rst    = reset;
        ev_req    = sample_req;
        ev_rd_ack = bus.bridge_read && bus.bridge_ack;
        ev_wr_ack = bus.bridge_write && bus.bridge_ack;
        ev_data   = bus.bridge_rd_data;

        @(posedge clk);
        #1;

        if (ev_rst) begin
            model_q.delete();
            rd_idx         = 0;
            underrun_model = 0;
            exp_valid      = 1'b0;
            exp_load_ack   = 1'b0;
            any_ack        = 1'b0;
            prev_strobe    = 1'b0;
            wait_cnt       = 0;
        end else begin
            exp_valid    = ev_req;
            exp_load_ack = ev_wr_ack;
            if (ev_req) begin
                if (model_q.size() > 0) begin
                    exp_out = model_q.pop_front();
                end else begin
                    exp_out = '0;
                    if (underrun_model < 255) underrun_model++;
                end
            end
            if (ev_rd_ack) begin
                model_q.push_back(ev_data);
                rd_idx++;
                read_count++;
            end
            if (ev_wr_ack) write_count++;
            if (ev_rd_ack || ev_wr_ack) begin
                any_ack         = 1'b1;
                edges_since_ack = 0;
            end else begin
                edges_since_ack++;
            end
        end

        checkOutput("sample_valid", sample_valid, exp_valid);
        if (exp_valid) begin
            checkOutput("sample_out", sample_out, exp_out);
            valid_count++;
        end
        checkOutput("load_ack", load_ack, exp_load_ack);
        checkOutput("underrun_cnt", underrun_cnt, underrun_model);
        checkOutput("no_rd_while_loading", bus.bridge_read & ~load_done, 0);

        if (bus.bridge_read) begin
            checkOutput("rd_addr", bus.bridge_addr, BASE + (rd_idx % LEN));
            checkOutput("rd_byte_en", bus.bridge_byte_en, 2'b11);
            checkOutput("single_strobe", bus.bridge_write, 0);
            if (!prev_strobe) begin
                checkOutput("rd_fifo_room", model_q.size() < DEPTH, 1);
                if (any_ack) checkOutput("rd_ack_spacing", edges_since_ack >= 2, 1);
            end
        end
        if (bus.bridge_write) begin
            checkOutput("wr_pending_word", ld_addr_q.size() > 0, 1);
            if (ld_addr_q.size() > 0) begin
                checkOutput("wr_addr", bus.bridge_addr, ld_addr_q[0]);
                checkOutput("wr_data", bus.bridge_wr_data, ld_data_q[0]);
            end
            checkOutput("wr_byte_en", bus.bridge_byte_en, 2'b11);
            if (!prev_strobe && any_ack)
                checkOutput("wr_ack_spacing", edges_since_ack >= 2, 1);
        end
        prev_strobe = bus.bridge_read || bus.bridge_write;

        if (load_ack) begin
            load_ack_count++;
            if (ld_addr_q.size() > 0) begin
                void'(ld_addr_q.pop_front());
                void'(ld_data_q.pop_front());
            end
        end
    endtask

    initial begin
        reset              = 1'b1;
        load_we            = 1'b0;
        load_addr          = '0;
        load_data          = '0;
        load_done          = 1'b0;
        play               = 1'b0;
        sample_req         = 1'b0;
        bus.bridge_ack     = 1'b0;
        bus.bridge_rd_data = '0;

        repeat (3) applyStimulus(1'b1, 1'b0);
        checkOutput("rst_read", bus.bridge_read, 0);
        checkOutput("rst_write", bus.bridge_write, 0);
        checkOutput("rst_addr", bus.bridge_addr, 0);
        checkOutput("rst_byte_en", bus.bridge_byte_en, 0);
        checkOutput("rst_wr_data", bus.bridge_wr_data, 0);
        checkOutput("rst_sample_out", sample_out, 0);

        // Loader writes three words, two-cycle bridge latency
        $display("[TB] load phase");
        ack_lat = 2;
        for (int i = 0; i < 3; i++) begin
            ld_addr_q.push_back(ADDR_W'(16 + i));
            ld_data_q.push_back(SAMPLE_W'($urandom));
        end
        for (int c = 0; c < 200 && ld_addr_q.size() > 0; c++) applyStimulus(1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("load_acks", load_ack_count, 3);
        checkOutput("load_writes", write_count, 3);
        checkOutput("load_no_reads", read_count, 0);

        // Streaming fills the FIFO and stops
        $display("[TB] stream phase");
        load_done = 1'b1;
        play      = 1'b1;
        ack_lat   = 1;
        repeat (30) applyStimulus(1'b0, 1'b0);
        checkOutput("stream_reads", read_count, 4);
        checkOutput("stream_idle", bus.bridge_read, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("first_sample_valid", sample_valid, 1);
        checkOutput("first_sample", sample_out, 16'h1000);
        repeat (10) applyStimulus(1'b0, 1'b0);
        checkOutput("refill_read", read_count, 5);

        // Pop coinciding with a read push keeps occupancy, so one more refill follows
        $display("[TB] push/pop corner");
        applyStimulus(1'b0, 1'b1);
        cnt_before = read_count;
        req_on_ack = 1'b1;
        for (int c = 0; c < 20 && read_count == cnt_before; c++) applyStimulus(1'b0, 1'b0);
        req_on_ack = 1'b0;
        checkOutput("corner_ack_seen", read_count, cnt_before + 1);
        repeat (20) applyStimulus(1'b0, 1'b0);
        checkOutput("corner_refill", read_count, cnt_before + 2);

        // Randomized traffic: pause/resume, latency, stray loader writes
        $display("[TB] random phase");
        for (int c = 0; c < 2000; c++) begin
            if (c % 50 == 0) begin
                play    = ($urandom_range(0, 3) != 0);
                ack_lat = $urandom_range(0, 3);
            end
            junk_we = ($urandom_range(0, 7) == 0);
            applyStimulus(1'b0, $urandom_range(0, 5) == 0);
        end
        junk_we = 1'b0;

        // Reset while a read is waiting for its ack
        $display("[TB] reset mid-read");
        play    = 1'b1;
        ack_lat = 10;
        for (int c = 0; c < 60 && !bus.bridge_read; c++) applyStimulus(1'b0, c % 4 == 0);
        checkOutput("rst_test_read_seen", bus.bridge_read, 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("rst_mid_read", bus.bridge_read, 0);
        checkOutput("rst_mid_underrun", underrun_cnt, 0);
        ack_lat = 1;
        for (int c = 0; c < 20 && !bus.bridge_read; c++) applyStimulus(1'b0, 1'b0);
        checkOutput("rst_restart_read", bus.bridge_read, 1);
        checkOutput("rst_restart_addr", bus.bridge_addr, BASE);

        // Underrun saturation with an empty, paused stream
        $display("[TB] underrun phase");
        play = 1'b0;
        applyStimulus(1'b1, 1'b0);
        valid_count = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1);
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("underrun_valids", valid_count, 300);
        checkOutput("underrun_sat", underrun_cnt, 8'hFF);
        checkOutput("underrun_no_reads", bus.bridge_read, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/sample_fetch_ctrl.md
# sample_fetch_ctrl

Sequencing controller and arbiter for the SDRAM Avalon bridge port of `mp3player_soc`. While the SD-card loader is running, it grants the bridge to the loader's word writes. Once loading is done and play is enabled, it streams 16-bit samples from a circular SDRAM region into a small FIFO. On each one-cycle request from the I2S serializer it hands the serializer one sample, or silence with an underrun count when the FIFO is empty.

## Interface
Parameters:
- `ADDR_W`, 26, bridge word-address width.
- `FIFO_DEPTH`, 4, sample FIFO entries; power of two, ≥2.
- `BASE_ADDR`, 26'h0000000, first sample word.
- `LEN`, 26'h0100000, number of sample words in the loop; ≥1.

Ports:
- `Clk` in 1: `MAX10_CLK1_50`; one clock, all logic on rising edge.
- `Reset` in 1: synchronous, active-high.
- `load_we` in 1: loader has a word to write (level; held until `load_ack`).
- `load_addr` in ADDR_W: loader word address.
- `load_data` in 16: loader write data.
- `load_done` in 1: loader finished; level, stays high.
- `load_ack` out 1: one-cycle pulse; loader word committed.
- `play` in 1: level; 1 = stream, 0 = pause.
- `bridge_addr` out ADDR_W: Avalon bridge address.
- `bridge_byte_en` out 2: byte enables.
- `bridge_read` out 1: read strobe.
- `bridge_write` out 1: write strobe.
- `bridge_wr_data` out 16: write data.
- `bridge_ack` in 1: bridge acknowledge.
- `bridge_rd_data` in 16: read data, valid when `bridge_ack`=1.
- `sample_req` in 1: one-cycle pulse from the I2S serializer, already in the `Clk` domain.
- `sample_out` out 16: sample to serializer.
- `sample_valid` out 1: one-cycle pulse; `sample_out` valid.
- `underrun_cnt` out 8: saturating count of empty-FIFO requests.

## Operation
- States (`fs_state_t`): FS_IDLE, FS_WRITE, FS_READ, FS_GAP.
- FS_IDLE:
  - if `load_we` && !`load_done` → FS_WRITE (loader has priority);
  - else if `load_done` && `play` && fifo_count < FIFO_DEPTH → FS_READ;
  - else stay.
  - `load_we` while `load_done`=1 is ignored.
- FS_WRITE:
  - drive `bridge_write`=1, `bridge_addr`=`load_addr`, `bridge_wr_data`=`load_data`, `bridge_byte_en`=2'b11.
  - Hold all of these until `bridge_ack`. On ack → FS_GAP and pulse `load_ack` on the next cycle.
- FS_READ:
  - drive `bridge_read`=1, `bridge_addr`=rd_ptr, `bridge_byte_en`=2'b11.
  - On ack: push `bridge_rd_data` into the FIFO and advance rd_ptr. After `BASE_ADDR+LEN-1`, rd_ptr wraps to `BASE_ADDR`. Then → FS_GAP.
- FS_GAP: all strobes 0 for exactly one cycle → FS_IDLE. The loader uses this cycle to advance after `load_ack`.
- At most one bridge transaction is outstanding. A push is only possible when count ≤ DEPTH-1, so the FIFO never overflows.
- `play` falling mid-read:
  - the read completes and is pushed;
  - no new read is issued;
  - rd_ptr and FIFO contents are retained (pause).
- `sample_req` with the FIFO non-empty: next cycle `sample_out`=head, `sample_valid`=1, pop.
- `sample_req` with the FIFO empty: next cycle `sample_out`=16'h0000, `sample_valid`=1, `underrun_cnt`+1, saturating at 8'hFF.
- Simultaneous push and pop: the count is unchanged. Data ordering is strict FIFO.
- The FIFO is served to `sample_req` regardless of `play`.

## Timing
- Reset values:
  - state FS_IDLE; rd_ptr=`BASE_ADDR`; FIFO empty;
  - all bridge outputs 0;
  - `load_ack`=0, `sample_out`=0, `sample_valid`=0, `underrun_cnt`=0.
- Reset mid-transaction: strobes drop on the next edge and the transaction is abandoned. The SDRAM write may or may not land.
- All outputs are registered.
- Bridge strobes assert 1 cycle after the FS_IDLE decision.
- `load_ack` arrives 1 cycle after the `bridge_ack` cycle.
- `sample_valid` arrives 1 cycle after `sample_req`.
- Minimum transaction spacing: ack cycle + FS_GAP + FS_IDLE, so 3 cycles from one ack to the next strobe assertion.
- rd_ptr arithmetic is ADDR_W-bit unsigned. The wrap compare is against `BASE_ADDR+LEN-1`, computed at elaboration.

## Structure
- `mp3_pkg`: `fs_state_t` enum, `SAMPLE_W`=16, `BYTE_EN_FULL`=2'b11.
- Sub-module `sample_fifo` (parameter DEPTH, 16-bit; push, pop, head, count, full, empty), instantiated once.
- The controller FSM, address pointer, request and underrun logic live in `sample_fetch_ctrl`.

## Test plan
- Load: `load_done`=0, three `load_we` words to 0x10/0x11/0x12 with `bridge_ack` 2 cycles after each strobe → three writes with matching addr/data, three `load_ack` pulses, each 1 cycle after ack; no reads.
- Stream: `load_done`=1, `play`=1, bridge returns 0x1000+addr, ack latency 1 → exactly 4 reads (addr 0..3), then `bridge_read` stays 0. A `sample_req` yields 0x1000 next cycle and a read of addr 4 follows.
- Wrap: LEN=3 with 7 sample requests spaced apart → read addresses 0,1,2,0,1,2,0; samples in the same order.
- Underrun: empty FIFO, `play`=0, 300 `sample_req` → 300 `sample_valid` with 0x0000; `underrun_cnt`=8'hFF.
- Corner: `sample_req` coincides with a read ack at count=4→3 push → count stays 3. `Reset` during FS_READ before ack → strobes 0 next cycle, rd_ptr=`BASE_ADDR`.
